reg_alu_exec: RTL
=================

// Module: reg_alu_exec
// PURPOSE
//  Execute stage downstream of the operator-entry front end. Consumes the latched opcode and two
//  register IDs, then runs one operation on an 8x8-bit register file. Writes the result back to
//  register A and exposes the result, flags and a register view port for the 7-seg display stage.
//  Multi-cycle FSM; one operation in flight at a time.
// PARAMETERS
//  RESET_VAL  8'd1  value loaded into every register on reset
// PORTS
//  clock      in   1  system clock, all state on posedge
//  reset      in   1  asynchronous, active-high; clears all state
//  start      in   1  1-cycle pulse: launch op using op_code/reg_a_id/reg_b_id/imm
//  op_code    in   4  operation select (cpu_pkg opcodes)
//  reg_a_id   in   3  operand A and destination register
//  reg_b_id   in   3  operand B register
//  imm        in   8  immediate for LDI
//  busy       out  1  high from cycle after accepted start until done
//  done       out  1  1-cycle pulse when op completes
//  illegal    out  1  valid with done: op_code reserved, nothing written
//  result     out  8  last computed value (held until next done)
//  flags      out  4  {C,V,N,Z}, held until next done
//  view_id    in   3  display read select
//  view_data  out  8  combinational read of regs[view_id]
// BEHAVIOUR
//  Reset: regs[0..7]=RESET_VAL, busy=0, done=0, illegal=0, result=0, flags=0, FSM=IDLE.
//  FSM: IDLE -(start)-> FETCH (latch A=regs[a], B=regs[b], op, ids, imm) -> EXEC (alu_core; latch
//   result/flags) -> WRITE (write regs[a] unless CMP/illegal; done=1) -> IDLE.
//  Latency: start sampled at edge N; done high in cycle N+3; write is visible on view_data from N+4.
//  start while busy is ignored (no queueing). start in the same cycle done is high is ignored.
//  Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical),
//   8 MOV A<=B, 9 INC A, A DEC A, B CMP (SUB, flags only), C LDI A<=imm, D-F reserved.
//  Arithmetic is 9-bit internally. Flags:
//   - C: carry-out for ADD/INC; borrow for SUB/CMP/DEC.
//   - C for shifts: the bit shifted out.
//   - V: two's-complement overflow for ADD/SUB/CMP/INC/DEC; 0 for all other ops.
//   - N = result[7]; Z = (result==0).
//   - Logic ops, MOV and LDI: C=0, V=0.
//  Reserved op: illegal=1 with done; regs, result and flags unchanged.
//  reg_a_id==reg_b_id is legal; both operands read the same old value.
//  view_id==dest during WRITE: view_data shows the old value that cycle.
//  Reset mid-operation aborts immediately: no write, no done, all regs return to RESET_VAL.
// CONFIGURATION
//  ALU_SAT_EN defined: ADD/SUB/INC/DEC with V=1 clamp to 8'h7F (positive overflow) or 8'h80
//   (negative overflow). V is still reported as 1; C is unchanged.
//  ALU_SAT_EN undefined: results wrap modulo 256.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_ADD..OP_LDI), FSM state encoding, flag bit indices.
//  alu_core: combinational sub-module (op, a, b, imm -> result, flags); the ALU_SAT_EN logic
//   lives here. reg_alu_exec holds the FSM, operand latches and register file.
// TESTING
//  1. Reset, then sweep view_id 0..7 -> every view_data=8'h01; busy=0, flags=0.
//  2. ADD a=0 b=1 -> done at start+3, result=8'h02, flags=0, view r0=8'h02.
//  3. LDI r3=8'h7F, then INC r3 -> result=8'h80, V=1, N=1 (with ALU_SAT_EN: 8'h7F, V=1, N=0).
//  4. DEC r2 (value 1) -> result=0, Z=1; then CMP r2,r1 -> C=1, N=1, r2 stays 0; then op 4'hE
//     -> illegal=1, flags unchanged.
//  5. Second start one cycle after the first -> ignored: exactly one done and one write.
//  6. Assert reset during EXEC of LDI r5=8'hAA -> no done, r5=8'h01; busy=0 after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the register/ALU execute stage.
//   Opcode encodings (OP_ADD..OP_LDI; 4'hD..4'hF are reserved),
//   the execute FSM state encoding, and the bit positions of the
//   {C,V,N,Z} flag vector.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_alu_exec_if.sv
// reg_alu_exec_if: operation launch, completion and display-view signals
// between the operator front end (master) and the execute stage (slave).
//   start/op_code/reg_a_id/reg_b_id/imm : launch an operation
//   busy/done/illegal/result/flags      : status and last result
//   view_id/view_data                   : combinational register view
interface reg_alu_exec_if;
  logic       start;
  logic [3:0] op_code;
  logic [2:0] reg_a_id;
  logic [2:0] reg_b_id;
  logic [7:0] imm;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [7:0] result;
  logic [3:0] flags;
  logic [2:0] view_id;
  logic [7:0] view_data;

  modport master (
    output start, op_code, reg_a_id, reg_b_id, imm, view_id,
    input  busy, done, illegal, result, flags, view_data
  );

  modport slave (
    input  start, op_code, reg_a_id, reg_b_id, imm, view_id,
    output busy, done, illegal, result, flags, view_data
  );
endinterface

// File: rtl/reg_alu_exec_alu.sv
// alu_core: combinational 8-bit ALU.
//   op, a, b, imm  -> result, flags {C,V,N,Z}, illegal (reserved opcode)
// Arithmetic is done 9 bits wide so bit 8 is the carry (ADD/INC) or the
// borrow (SUB/CMP/DEC).
// Build option: ALU_SAT_EN -- when defined, ADD/SUB/INC/DEC results that
// overflow clamp to 8'h7F / 8'h80; V stays set and C is unaffected.
module alu_core
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] result,
  output logic [3:0] flags,
  output logic       illegal
);

  logic [7:0] opnd;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] res;
  logic       c;
  logic       v;
  logic       arith;

  // INC/DEC reuse the adder/subtractor with a constant 1 operand
  assign opnd  = (op == OP_INC || op == OP_DEC) ? 8'd1 : b;
  assign sum9  = {1'b0, a} + {1'b0, opnd};
  assign diff9 = {1'b0, a} - {1'b0, opnd};

  always_comb begin
    res     = 8'h00;
    c       = 1'b0;
    v       = 1'b0;
    arith   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        res   = sum9[7:0];
        c     = sum9[8];
        v     = (a[7] == opnd[7]) && (sum9[7] != a[7]);
        arith = 1'b1;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        res   = diff9[7:0];
        c     = diff9[8];
        v     = (a[7] != opnd[7]) && (diff9[7] != a[7]);
        arith = (op != OP_CMP);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = {a[6:0], 1'b0};
        c   = a[7];
      end
      OP_SHR: begin
        res = {1'b0, a[7:1]};
        c   = a[0];
      end
      OP_MOV: res = b;
      OP_LDI: res = imm;
      default: illegal = 1'b1;
    endcase
`ifdef ALU_SAT_EN
    // overflow direction follows the sign of A: positive A can only
    // overflow upward, negative A only downward
    if (arith && v)
      res = a[7] ? 8'h80 : 8'h7F;
`else
    if (arith && v)
      res = res;
`endif
  end

  assign result         = res;
  assign flags[FLAG_C]  = c;
  assign flags[FLAG_V]  = v;
  assign flags[FLAG_N]  = res[7];
  assign flags[FLAG_Z]  = (res == 8'h00);

endmodule

// File: rtl/reg_alu_exec.sv
// reg_alu_exec: execute stage with an 8x8 register file.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : start/op_code/reg_a_id/reg_b_id/imm in,
//                  busy/done/illegal/result/flags out,
//                  view_id in / view_data out (combinational read)
// One op in flight: IDLE -> FETCH -> EXEC -> WRITE -> IDLE. A start seen
// outside IDLE (including the WRITE/done cycle) is dropped.
// Build option: ALU_SAT_EN (see alu_core) selects saturating arithmetic.
module reg_alu_exec
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'd1
) (
  input  logic           clock,
  input  logic           reset,
  reg_alu_exec_if.slave  bus
);

  state_t     state;
  logic [7:0] regs [8];
  logic [3:0] op_q;
  logic [2:0] a_id_q;
  logic [2:0] b_id_q;
  logic [7:0] imm_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       wr_q;
  logic       busy_q;
  logic       done_q;
  logic       illegal_q;
  logic [7:0] result_q;
  logic [3:0] flags_q;

  logic [7:0] alu_res;
  logic [3:0] alu_flags;
  logic       alu_ill;

  alu_core u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .imm     (imm_q),
    .result  (alu_res),
    .flags   (alu_flags),
    .illegal (alu_ill)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= RESET_VAL;
      state     <= ST_IDLE;
      op_q      <= 4'h0;
      a_id_q    <= 3'd0;
      b_id_q    <= 3'd0;
      imm_q     <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 8'h00;
      flags_q   <= 4'h0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op_code;
            a_id_q <= bus.reg_a_id;
            b_id_q <= bus.reg_b_id;
            imm_q  <= bus.imm;
            busy_q <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          a_q   <= regs[a_id_q];
          b_q   <= regs[b_id_q];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          done_q    <= 1'b1;
          illegal_q <= alu_ill;
          if (!alu_ill) begin
            result_q <= alu_res;
            flags_q  <= alu_flags;
          end
          wr_q  <= !alu_ill && (op_q != OP_CMP);
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          // the write lands at the end of the done cycle, so a view of the
          // destination shows the old value while done is high
          if (wr_q) regs[a_id_q] <= result_q;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.view_data = regs[bus.view_id];

endmodule
